csi_pkt_sequencer: RTL and testbench
====================================

CSI_PKT_SEQUENCER -- requirements
Module: csi_pkt_sequencer

Interface
REQ-001 SHALL have parameter LINE_WC, default 16'd800, giving the long-packet payload byte count per line (640 RAW10 pixels).
REQ-002 SHALL have parameter DATA_DELAY, default 3, giving the byte-data pipeline depth in cycles (range 1..7).
REQ-003 SHALL have parameter VC_ID, default 2'b00, giving the virtual channel.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  byte clock from the D-PHY.
- reset_n  in  1  asynchronous, active-low reset.
- fv_start_i  in  1  frame-start pulse.
- fv_end_i  in  1  frame-end pulse.
- lv_start_i  in  1  line-start pulse.
- lv_end_i  in  1  line-end pulse.
- byte_en_i  in  1  payload byte valid.
- byte_data_i  in  8  payload byte.
- hs_rdy_i  in  1  D-PHY high-speed ready.
- txfr_en_o  out  1  hs_rdy_i registered once, returned to the packer.
- sp_en_o  out  1  short-packet strobe.
- lp_en_o  out  1  long-packet strobe.
- vc_o  out  2  virtual channel.
- dt_o  out  6  data type.
- wc_o  out  16  word count.
- byte_en_o  out  1  delayed byte valid.
- byte_data_o  out  8  delayed byte.
- len_err_o  out  1  sticky line-length error.
- seq_err_o  out  1  sticky sequencing error.
- frame_cnt_o  out  16  frames completed.

Function
REQ-005 SHALL run a state machine with states IDLE, IN_FRAME, IN_LINE and FRAME_END.
REQ-006 In IDLE, fv_start_i SHALL produce in the next cycle: sp_en_o=1 for exactly 1 cycle, dt_o=6'h00 and wc_o=FS word count; state then becomes IN_FRAME.
REQ-007 In IN_FRAME, lv_start_i SHALL produce in the next cycle: lp_en_o=1 for 1 cycle, dt_o=6'h2B and wc_o=LINE_WC; state becomes IN_LINE and the byte counter clears.
REQ-008 In IN_LINE, each byte_en_i SHALL increment a 16-bit payload counter, saturating at 16'hFFFF.
REQ-009 In IN_LINE, lv_end_i SHALL return the state to IN_FRAME; if the counter (including a byte arriving that same cycle) is not equal to LINE_WC, len_err_o SHALL set.
REQ-010 In IN_FRAME, fv_end_i SHALL produce in the next cycle: sp_en_o=1, dt_o=6'h01 and wc_o=FE word count; frame_cnt_o SHALL increment, wrapping at 16 bits; state passes through FRAME_END for 1 cycle, then IDLE.
REQ-011 fv_end_i received in IN_LINE SHALL close the line with the REQ-009 check, then emit FE as in REQ-010.
REQ-012 A start/end pulse illegal in the current state SHALL be ignored and SHALL set seq_err_o: fv_start_i outside IDLE, lv_start_i outside IN_FRAME, lv_end_i outside IN_LINE.
REQ-013 If fv_start_i and fv_end_i are high together in IDLE, FS SHALL be emitted and FE dropped, with seq_err_o set.
REQ-014 dt_o and wc_o SHALL hold their last values between strobes.
REQ-015 byte_data_o and byte_en_o SHALL equal byte_data_i and byte_en_i delayed by exactly DATA_DELAY cycles, independent of the state machine.
REQ-016 vc_o SHALL equal VC_ID at all times.
REQ-017 len_err_o and seq_err_o SHALL clear only on reset.

Reset
REQ-018 While reset_n=0, all outputs SHALL be 0 except vc_o (=VC_ID); state SHALL be IDLE and the pipeline, counters and flags SHALL be cleared.
REQ-019 Reset asserted mid-frame SHALL abort the frame with no FE emitted; after release the block SHALL wait for a new fv_start_i.

Configuration
REQ-020 Macro CSI_FRAME_NUM_EN:
- Defined: FS and FE wc_o SHALL carry the frame number, 1..65535 wrapping to 1 (0 skipped), incremented at each FS, with FE matching its FS.
- Undefined: FS and FE wc_o SHALL be 16'h0000 and no frame-number logic is built.

Structure
REQ-021 A shared package csi_pkg SHALL hold the DT_FS=6'h00, DT_FE=6'h01 and DT_RAW10=6'h2B constants and the sequencer state enum.
REQ-022 The byte delay line SHALL be a sub-module csi_byte_delay, parameterised by depth.

Verification
REQ-023 Scenario, normal frame: FS, 2 lines of 800 bytes, FE -> sp_en(dt=00), lp_en(dt=2B, wc=800) twice, sp_en(dt=01); frame_cnt_o=1; no errors.
REQ-024 Scenario, short line: line of 799 bytes -> len_err_o=1 after lv_end_i; next frame still sequenced correctly.
REQ-025 Scenario, illegal start: lv_start_i while in IDLE -> no lp_en_o and seq_err_o=1.
REQ-026 Scenario, frame numbering: with CSI_FRAME_NUM_EN, three frames -> FS/FE wc_o values 1,1,2,2,3,3; without the macro, all 0.
REQ-027 Scenario, data delay: byte 8'hA5 at cycle t -> byte_data_o=8'hA5 with byte_en_o=1 at t+3.
REQ-028 Scenario, reset mid-line: reset after 400 bytes -> all outputs 0 and no FE; next frame normal with frame_cnt_o restarting at 1.

Source files
------------

// File: rtl/csi_pkg.sv
// Shared definitions for the CSI-2 packet sequencer: data-type codes,
// the sequencer state encoding and small counter helpers.
package csi_pkg;

  // CSI-2 data types emitted by the sequencer
  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_IN_FRAME  = 2'd1,
    ST_IN_LINE   = 2'd2,
    ST_FRAME_END = 2'd3
  } seq_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // Next frame number: 1..65535, wrapping back to 1 so that 0 never appears
  function automatic logic [15:0] frame_num_next(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = 16'd1;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csi_byte_delay.sv
// Fixed-depth delay line for the payload byte stream. The valid bit and
// data byte travel together so they stay aligned at the output. DEPTH is
// expected in 1..7; the output is taken straight from the last stage flop.
module csi_byte_delay
  import csi_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic       en_o,
  output logic [7:0] data_o
);

  logic [DEPTH-1:0]      en_q;
  logic [DEPTH-1:0]      en_d;
  logic [DEPTH-1:0][7:0] data_q;
  logic [DEPTH-1:0][7:0] data_d;

  // Shift every stage one step toward the output
  always_comb begin
    en_d      = {DEPTH{1'b0}};
    data_d    = {DEPTH{8'h00}};
    en_d[0]   = en_i;
    data_d[0] = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      en_d[i]   = en_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Pipeline registers, cleared on reset so no stale bytes leak out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= {DEPTH{1'b0}};
      data_q <= {DEPTH{8'h00}};
    end else begin
      en_q   <= en_d;
      data_q <= data_d;
    end
  end

  assign en_o   = en_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/csi_pkt_sequencer.sv
// CSI-2 packet sequencer. Turns frame/line start/end pulses into
// short-packet (FS/FE) and long-packet (RAW10 line) header strobes, checks
// line length, flags out-of-order pulses and delays the payload bytes so
// they line up with the packer downstream.
//
// Optional build macro CSI_FRAME_NUM_EN: when defined, FS/FE word counts
// carry a 1..65535 frame number; when undefined they are 16'h0000.
module csi_pkt_sequencer
  import csi_pkg::*;
#(
  parameter logic [15:0] LINE_WC    = 16'd800,
  parameter int          DATA_DELAY = 3,
  parameter logic [1:0]  VC_ID      = 2'b00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fv_start_i,
  input  logic        fv_end_i,
  input  logic        lv_start_i,
  input  logic        lv_end_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_data_i,
  input  logic        hs_rdy_i,
  output logic        txfr_en_o,
  output logic        sp_en_o,
  output logic        lp_en_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic [15:0] wc_o,
  output logic        byte_en_o,
  output logic [7:0]  byte_data_o,
  output logic        len_err_o,
  output logic        seq_err_o,
  output logic [15:0] frame_cnt_o
);

  seq_state_e  state_q;
  seq_state_e  state_d;
  logic        sp_en_q;
  logic        sp_en_d;
  logic        lp_en_q;
  logic        lp_en_d;
  logic [5:0]  dt_q;
  logic [5:0]  dt_d;
  logic [15:0] wc_q;
  logic [15:0] wc_d;
  logic        len_err_q;
  logic        len_err_d;
  logic        seq_err_q;
  logic        seq_err_d;
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;
  logic [15:0] byte_cnt_q;
  logic [15:0] byte_cnt_d;
  logic        txfr_en_q;
  logic        txfr_en_d;

  logic        illegal_s;
  logic [15:0] line_cnt_s;
  logic [15:0] fs_wc_s;
  logic [15:0] fe_wc_s;

`ifdef CSI_FRAME_NUM_EN
  logic [15:0] frame_num_q;
  logic [15:0] frame_num_d;

  // FS carries the number about to be assigned, FE repeats the current one
  assign fs_wc_s = frame_num_next(frame_num_q);
  assign fe_wc_s = frame_num_q;
`else
  assign fs_wc_s = 16'h0000;
  assign fe_wc_s = 16'h0000;
`endif

  // Byte count including a byte that arrives in the same cycle as a line end
  assign line_cnt_s = byte_en_i ? sat_inc16(byte_cnt_q) : byte_cnt_q;

  assign txfr_en_d = hs_rdy_i;

  // Next-state and next-output computation for the packet sequencer
  always_comb begin
    state_d     = state_q;
    sp_en_d     = 1'b0;
    lp_en_d     = 1'b0;
    dt_d        = dt_q;
    wc_d        = wc_q;
    len_err_d   = len_err_q;
    frame_cnt_d = frame_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    illegal_s   = 1'b0;
`ifdef CSI_FRAME_NUM_EN
    frame_num_d = frame_num_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // An FE with nothing open (alone or alongside FS) is dropped
        illegal_s = fv_end_i | lv_start_i | lv_end_i;
        if (fv_start_i) begin
          sp_en_d = 1'b1;
          dt_d    = DT_FS;
          wc_d    = fs_wc_s;
          state_d = ST_IN_FRAME;
`ifdef CSI_FRAME_NUM_EN
          frame_num_d = fs_wc_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IN_FRAME: begin
        // FE wins over a coincident line start; the line start is flagged
        illegal_s = fv_start_i | lv_end_i | (fv_end_i & lv_start_i);
        if (fv_end_i) begin
          sp_en_d     = 1'b1;
          dt_d        = DT_FE;
          wc_d        = fe_wc_s;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_FRAME_END;
        end else if (lv_start_i) begin
          lp_en_d    = 1'b1;
          dt_d       = DT_RAW10;
          wc_d       = LINE_WC;
          byte_cnt_d = 16'd0;
          state_d    = ST_IN_LINE;
        end else begin
          state_d = ST_IN_FRAME;
        end
      end
      ST_IN_LINE: begin
        illegal_s  = fv_start_i | lv_start_i;
        byte_cnt_d = line_cnt_s;
        if (fv_end_i || lv_end_i) begin
          // Either end pulse closes the line and triggers the length check
          if (line_cnt_s != LINE_WC) begin
            len_err_d = 1'b1;
          end else begin
            len_err_d = len_err_q;
          end
          if (fv_end_i) begin
            sp_en_d     = 1'b1;
            dt_d        = DT_FE;
            wc_d        = fe_wc_s;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_FRAME_END;
          end else begin
            state_d = ST_IN_FRAME;
          end
        end else begin
          state_d = ST_IN_LINE;
        end
      end
      ST_FRAME_END: begin
        // One settling cycle after FE; any pulse here is out of order
        illegal_s = fv_start_i | fv_end_i | lv_start_i | lv_end_i;
        state_d   = ST_IDLE;
      end
      default: begin
        illegal_s = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
    seq_err_d = seq_err_q | illegal_s;
  end

  // Sequencer state, sticky flags, counters and registered header outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sp_en_q     <= 1'b0;
      lp_en_q     <= 1'b0;
      dt_q        <= 6'h00;
      wc_q        <= 16'h0000;
      len_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      frame_cnt_q <= 16'h0000;
      byte_cnt_q  <= 16'h0000;
      txfr_en_q   <= 1'b0;
`ifdef CSI_FRAME_NUM_EN
      frame_num_q <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      sp_en_q     <= sp_en_d;
      lp_en_q     <= lp_en_d;
      dt_q        <= dt_d;
      wc_q        <= wc_d;
      len_err_q   <= len_err_d;
      seq_err_q   <= seq_err_d;
      frame_cnt_q <= frame_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      txfr_en_q   <= txfr_en_d;
`ifdef CSI_FRAME_NUM_EN
      frame_num_q <= frame_num_d;
`endif
    end
  end

  // Payload bytes bypass the state machine through a fixed delay line
  csi_byte_delay #(
    .DEPTH (DATA_DELAY)
  ) u_byte_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (byte_en_i),
    .data_i  (byte_data_i),
    .en_o    (byte_en_o),
    .data_o  (byte_data_o)
  );

  assign txfr_en_o   = txfr_en_q;
  assign sp_en_o     = sp_en_q;
  assign lp_en_o     = lp_en_q;
  assign vc_o        = VC_ID;
  assign dt_o        = dt_q;
  assign wc_o        = wc_q;
  assign len_err_o   = len_err_q;
  assign seq_err_o   = seq_err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_csi_pkt_sequencer.sv
// Self-checking bench for csi_pkt_sequencer. Expected header strobes and
// delayed bytes are queued when stimulus is driven and compared on the
// cycle they are due; a vector table covers pulse legality per state.
module tb_csi_pkt_sequencer;

  localparam logic [15:0] LINE_WC    = 16'd800;
  localparam int          DATA_DELAY = 3;
  localparam logic [1:0]  VC_ID      = 2'b00;

  localparam int K_NONE = 0;
  localparam int K_FS   = 1;
  localparam int K_FE   = 2;
  localparam int K_LS   = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fv_start_i = 1'b0;
  logic        fv_end_i = 1'b0;
  logic        lv_start_i = 1'b0;
  logic        lv_end_i = 1'b0;
  logic        byte_en_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        hs_rdy_i = 1'b0;
  logic        txfr_en_o;
  logic        sp_en_o;
  logic        lp_en_o;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] wc_o;
  logic        byte_en_o;
  logic [7:0]  byte_data_o;
  logic        len_err_o;
  logic        seq_err_o;
  logic [15:0] frame_cnt_o;

  csi_pkt_sequencer #(
    .LINE_WC    (LINE_WC),
    .DATA_DELAY (DATA_DELAY),
    .VC_ID      (VC_ID)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fv_start_i  (fv_start_i),
    .fv_end_i    (fv_end_i),
    .lv_start_i  (lv_start_i),
    .lv_end_i    (lv_end_i),
    .byte_en_i   (byte_en_i),
    .byte_data_i (byte_data_i),
    .hs_rdy_i    (hs_rdy_i),
    .txfr_en_o   (txfr_en_o),
    .sp_en_o     (sp_en_o),
    .lp_en_o     (lp_en_o),
    .vc_o        (vc_o),
    .dt_o        (dt_o),
    .wc_o        (wc_o),
    .byte_en_o   (byte_en_o),
    .byte_data_o (byte_data_o),
    .len_err_o   (len_err_o),
    .seq_err_o   (seq_err_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        sp;
    logic        lp;
    logic [5:0]  dt;
    logic [15:0] wc;
  } strobe_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } byte_t;

  typedef struct {
    int          pre;      // 0 idle, 1 in frame, 2 in line
    logic        fvs;
    logic        fve;
    logic        lvs;
    logic        lve;
    int          kind;     // header expected one cycle later
    logic        exp_seq;
    logic        exp_len;
    logic [15:0] exp_fc;
  } vec_t;

  strobe_t     sq[$];
  byte_t       bq[$];
  vec_t        vecs[12];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [5:0]  last_dt = 6'h00;
  logic [15:0] last_wc = 16'h0000;
  logic [15:0] fnum = 16'h0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle and compare everything that is due on this cycle
  task automatic tick();
    strobe_t e;
    byte_t   b;
    @(negedge clk);
    cyc++;
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      e = sq.pop_front();
      chk($sformatf("strobe@%0d", cyc), 64'({vc_o, sp_en_o, lp_en_o, dt_o, wc_o}),
          64'({VC_ID, e.sp, e.lp, e.dt, e.wc}));
      last_dt = e.dt;
      last_wc = e.wc;
    end else begin
      chk($sformatf("quiet_hold@%0d", cyc), 64'({vc_o, sp_en_o, lp_en_o, dt_o, wc_o}),
          64'({VC_ID, 1'b0, 1'b0, last_dt, last_wc}));
    end
    if (bq.size() > 0 && bq[0].cyc == cyc) begin
      b = bq.pop_front();
      chk($sformatf("byte@%0d", cyc), 64'({byte_en_o, byte_data_o}), 64'({1'b1, b.data}));
    end else begin
      chk($sformatf("no_byte@%0d", cyc), 64'(byte_en_o), 64'(1'b0));
    end
  endtask

  task automatic push_strobe(input int kind);
    strobe_t e;
    e.cyc = cyc + 1;
    e.sp  = (kind == K_FS) || (kind == K_FE);
    e.lp  = (kind == K_LS);
    if (kind == K_FS) begin
`ifdef CSI_FRAME_NUM_EN
      fnum = (fnum == 16'hFFFF) ? 16'd1 : fnum + 16'd1;
      e.wc = fnum;
`else
      e.wc = 16'h0000;
`endif
      e.dt = 6'h00;
    end else if (kind == K_FE) begin
`ifdef CSI_FRAME_NUM_EN
      e.wc = fnum;
`else
      e.wc = 16'h0000;
`endif
      e.dt = 6'h01;
    end else begin
      e.dt = 6'h2B;
      e.wc = LINE_WC;
    end
    sq.push_back(e);
  endtask

  // Drive one cycle of inputs and record what they should produce
  task automatic drive(input logic fvs, input logic fve, input logic lvs, input logic lve,
                       input logic ben, input logic [7:0] bd, input int kind);
    byte_t b;
    fv_start_i  = fvs;
    fv_end_i    = fve;
    lv_start_i  = lvs;
    lv_end_i    = lve;
    byte_en_i   = ben;
    byte_data_i = bd;
    if (ben) begin
      b.cyc  = cyc + DATA_DELAY;
      b.data = bd;
      bq.push_back(b);
    end
    if (kind != K_NONE) push_strobe(kind);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, K_NONE);
  endtask

  task automatic send_fs();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, K_FS);
  endtask

  task automatic send_fe();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, K_FE);
    idle();
  endtask

  // Line start, n payload bytes, line end (optionally sharing the last byte)
  task automatic send_line(input int n, input bit last_with_end);
    int body;
    body = last_with_end ? n - 1 : n;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, K_LS);
    for (int i = 0; i < body; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), K_NONE);
    drive(1'b0, 1'b0, 1'b0, 1'b1, last_with_end, 8'($urandom), K_NONE);
  endtask

  // Assert reset (possibly mid-frame), check the reset image, then release
  task automatic do_reset();
    reset_n = 1'b0;
    fv_start_i = 1'b0; fv_end_i = 1'b0; lv_start_i = 1'b0; lv_end_i = 1'b0;
    byte_en_i = 1'b0; byte_data_i = 8'h00; hs_rdy_i = 1'b0;
    sq.delete();
    bq.delete();
    last_dt = 6'h00;
    last_wc = 16'h0000;
    fnum    = 16'h0000;
    #1;
    chk("reset_outputs",
        64'({txfr_en_o, sp_en_o, lp_en_o, vc_o, dt_o, wc_o, byte_en_o, byte_data_o,
             len_err_o, seq_err_o, frame_cnt_o}),
        64'({1'b0, 1'b0, 1'b0, VC_ID, 6'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000}));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    vecs[0]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, K_FS,   1'b0, 1'b0, 16'd0};
    vecs[1]  = '{0, 1'b1, 1'b1, 1'b0, 1'b0, K_FS,   1'b1, 1'b0, 16'd0};
    vecs[2]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, K_NONE, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, K_NONE, 1'b1, 1'b0, 16'd0};
    vecs[4]  = '{1, 1'b0, 1'b0, 1'b1, 1'b0, K_LS,   1'b0, 1'b0, 16'd0};
    vecs[5]  = '{1, 1'b1, 1'b0, 1'b0, 1'b0, K_NONE, 1'b1, 1'b0, 16'd0};
    vecs[6]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, K_FE,   1'b0, 1'b0, 16'd1};
    vecs[7]  = '{1, 1'b0, 1'b0, 1'b0, 1'b1, K_NONE, 1'b1, 1'b0, 16'd0};
    vecs[8]  = '{2, 1'b0, 1'b0, 1'b1, 1'b0, K_NONE, 1'b1, 1'b0, 16'd0};
    vecs[9]  = '{2, 1'b0, 1'b0, 1'b0, 1'b1, K_NONE, 1'b0, 1'b1, 16'd0};
    vecs[10] = '{2, 1'b0, 1'b1, 1'b0, 1'b0, K_FE,   1'b0, 1'b1, 16'd1};
    vecs[11] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, K_NONE, 1'b1, 1'b0, 16'd0};

    do_reset();

    // hs_rdy_i is returned one cycle later
    hs_rdy_i = 1'b1;
    tick();
    chk("txfr_en_high", 64'(txfr_en_o), 64'(1'b1));
    hs_rdy_i = 1'b0;
    tick();
    chk("txfr_en_low", 64'(txfr_en_o), 64'(1'b0));

    // Pulse legality per state
    for (int v = 0; v < 12; v++) begin
      do_reset();
      if (vecs[v].pre >= 1) send_fs();
      if (vecs[v].pre == 2) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, K_LS);
      drive(vecs[v].fvs, vecs[v].fve, vecs[v].lvs, vecs[v].lve, 1'b0, 8'h00, vecs[v].kind);
      idle();
      idle();
      chk($sformatf("vec%0d_flags", v), 64'({seq_err_o, len_err_o, frame_cnt_o}),
          64'({vecs[v].exp_seq, vecs[v].exp_len, vecs[v].exp_fc}));
    end

    // Normal frame: two full lines, the second ending on its last byte
    do_reset();
    send_fs();
    send_line(800, 1'b0);
    send_line(800, 1'b1);
    send_fe();
    chk("normal_flags", 64'({seq_err_o, len_err_o, frame_cnt_o}), 64'({1'b0, 1'b0, 16'd1}));

    // Short line, then a clean frame that must still be sequenced
    do_reset();
    send_fs();
    send_line(799, 1'b0);
    chk("short_len_err", 64'(len_err_o), 64'(1'b1));
    send_fe();
    send_fs();
    send_line(800, 1'b1);
    send_fe();
    chk("short_next_flags", 64'({seq_err_o, len_err_o, frame_cnt_o}), 64'({1'b0, 1'b1, 16'd2}));

    // Frame numbering across three frames (word counts checked by scoreboard)
    do_reset();
    for (int f = 0; f < 3; f++) begin
      send_fs();
      send_fe();
    end
    chk("three_frames_cnt", 64'({seq_err_o, frame_cnt_o}), 64'({1'b0, 16'd3}));

    // Data delay: one byte appears exactly DATA_DELAY cycles later
    do_reset();
    t0 = cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, K_NONE);
    idle();
    idle();
    chk("delay_a5_cycle", 64'(cyc - t0), 64'(3));
    chk("delay_a5", 64'({byte_en_o, byte_data_o}), 64'({1'b1, 8'hA5}));
    idle();
    chk("delay_a5_gone", 64'(byte_en_o), 64'(1'b0));

    // Reset in the middle of a line: no FE, then a fresh normal frame
    do_reset();
    send_fs();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, K_LS);
    for (int i = 0; i < 400; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), K_NONE);
    do_reset();
    for (int i = 0; i < 5; i++) idle();
    send_fs();
    send_line(800, 1'b0);
    send_fe();
    chk("after_reset_flags", 64'({seq_err_o, len_err_o, frame_cnt_o}), 64'({1'b0, 1'b0, 16'd1}));

    for (int i = 0; i < 6; i++) idle();
    chk("scoreboard_drained", 64'(sq.size() + bq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
